dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//
// Load/store unit between a simple valid/ready request port and a word-wide
// data memory with a combinational read port. It handles byte, half and word
// accesses with little-endian lanes, and sign- or zero-extends loads. Sub-word
// stores are done as read-modify-write. Misaligned or illegal-size requests are
// answered with an error flag and never touch memory.
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   req_valid      request present
//   req_ready      high only in IDLE; request accepted when valid & ready
//   req_we         1 = store, 0 = load
//   req_size       00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned   1 = zero-extend load data, 0 = sign-extend
//   req_addr       byte address
//   req_wdata      store data, right-aligned
//   rsp_valid      one-cycle completion pulse (no backpressure)
//   rsp_rdata      extended load data (0 for stores and errors)
//   rsp_misaligned error flag, qualified by rsp_valid
//   mem_we         memory write enable
//   mem_a          word-aligned memory address
//   mem_wd         memory write data
//   mem_rd         memory read data, combinational in mem_a
// -----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [SIZE-1:0] req_addr,
    input  logic [SIZE-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [SIZE-1:0] rsp_rdata,
    output logic            rsp_misaligned,
    output logic            mem_we,
    output logic [SIZE-1:0] mem_a,
    output logic [SIZE-1:0] mem_wd,
    input  logic [SIZE-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } access_size_e;

    state_e            state, state_d;

    // Request fields captured on acceptance; the requester may change its
    // inputs freely afterwards.
    logic [SIZE-1:0]   addr_q;
    logic              we_q;
    access_size_e      size_q;
    logic              unsigned_q;
    // Holds the store data, and for sub-word stores is overwritten with the
    // merged word at the end of the read phase.
    logic [SIZE-1:0]   wd_q;

    logic [SIZE-1:0]   rdata_q, rdata_d;
    logic              mis_q, mis_d;

    logic              accept;
    logic              misaligned_req;
    logic [1:0]        lane;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [SIZE-1:0]   load_ext;
    logic [SIZE-1:0]   merged;

    // -------------------------------------------------------------------------
    // Alignment check on the incoming (not yet latched) request
    // -------------------------------------------------------------------------
    always_comb begin
        unique case (access_size_e'(req_size))
            SZ_BYTE: misaligned_req = 1'b0;
            SZ_HALF: misaligned_req = req_addr[0];
            SZ_WORD: misaligned_req = (req_addr[1:0] != 2'b00);
            default: misaligned_req = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // Lane extraction for loads and lane merge for sub-word stores
    // -------------------------------------------------------------------------
    assign lane    = addr_q[1:0];
    assign ld_byte = mem_rd[{lane, 3'b000} +: 8];
    assign ld_half = mem_rd[{lane[1], 4'b0000} +: 16];

    always_comb begin
        unique case (size_q)
            SZ_BYTE: load_ext = unsigned_q ? {{(SIZE-8){1'b0}}, ld_byte}
                                           : {{(SIZE-8){ld_byte[7]}}, ld_byte};
            SZ_HALF: load_ext = unsigned_q ? {{(SIZE-16){1'b0}}, ld_half}
                                           : {{(SIZE-16){ld_half[15]}}, ld_half};
            default: load_ext = mem_rd;
        endcase
    end

    always_comb begin
        merged = mem_rd;
        unique case (size_q)
            SZ_BYTE: merged[{lane, 3'b000} +: 8]     = wd_q[7:0];
            SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = wd_q[15:0];
            default: merged = wd_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        rdata_d = '0;
        mis_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (misaligned_req) begin
                        state_d = RESP;
                        mis_d   = 1'b1;
                    end else if (req_we && (access_size_e'(req_size) == SZ_WORD)) begin
                        state_d = WRITE;
                    end else begin
                        // Loads and sub-word stores both need the current word.
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (we_q) begin
                    state_d = WRITE;
                end else begin
                    state_d = RESP;
                    rdata_d = load_ext;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // register samples the values that existed before this edge.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    // NOTE: all of these are reset, not just the control state, because
    // mem_a, mem_wd and the response outputs must read 0 straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            wd_q       <= '0;
            rdata_q    <= '0;
            mis_q      <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            if (accept) begin
                addr_q     <= req_addr;
                we_q       <= req_we;
                size_q     <= access_size_e'(req_size);
                unsigned_q <= req_unsigned;
                wd_q       <= req_wdata;
            end else if (state == READ && we_q) begin
                wd_q <= merged;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_ready      = (state == IDLE);
    assign rsp_valid      = (state == RESP);
    assign rsp_rdata      = rdata_q;
    assign rsp_misaligned = mis_q;

    // rst gates the write strobe combinationally so that a reset arriving in
    // the WRITE cycle aborts the store before the memory samples it.
    assign mem_we = (state == WRITE) && !rst;
    assign mem_a  = {addr_q[SIZE-1:2], 2'b00};
    assign mem_wd = (state == WRITE) ? wd_q : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
//
// Drives dmem_ctrl against a word-wide memory model and compares every
// response with a byte-addressed reference memory kept in the bench.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks = 0;
    int errors = 0;

    dmem_ctrl #(.SIZE(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .mem_we         (mem_we),
        .mem_a          (mem_a),
        .mem_wd         (mem_wd),
        .mem_rd         (mem_rd)
    );

    always #5 clk = ~clk;

    // Data memory: 256 words, word i preloaded with its byte address 4*i.
    logic [31:0] dmem [0:255];
    logic        preload;
    assign mem_rd = dmem[mem_a[9:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 32'(i * 4);
        end else if (mem_we) begin
            dmem[mem_a[9:2]] <= mem_wd;
        end
    end

    // Reference memory, byte addressed (address bits above 9 alias).
    logic [7:0] ref_mem [0:1023];

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] addr);
        if (sz == 2'd3) return 1'b1;
        return (int'(addr[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        logic [31:0] w = '0;
        int base = int'(addr[9:2]) * 4;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[base + i];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                               input logic [31:0] addr);
        longint unsigned v = 0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++)
            v = v + (longint'(ref_mem[int'(addr[9:0]) + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1])
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v[31:0];
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] addr,
                               input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++)
            ref_mem[int'(addr[9:0]) + i] = wd[8*i +: 8];
    endtask

    // ---------------- transaction driver ----------------
    // Called at a negedge with the controller idle. Returns latency in cycles
    // from the accepting edge to the rsp_valid cycle (0 on timeout).
    task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output bit mis,
                          output int we_cnt, output logic [31:0] wa,
                          output logic [31:0] wdv, output bit busy_ready);
        int guard = 0;
        lat = 0; we_cnt = 0; rd = 'x; mis = 1'bx; wa = 'x; wdv = 'x; busy_ready = 1'b0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        // Scramble the request port: the latched copy must be used.
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cnt++;
                wa  = mem_a;
                wdv = mem_wd;
            end
            if (rsp_valid) begin
                lat = c;
                rd  = rsp_rdata;
                mis = rsp_misaligned;
                break;
            end
            if (req_ready) busy_ready = 1'b1;
        end
        @(negedge clk);
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        check("ready_after_rsp", 32'(req_ready), 32'd1);
    endtask

    // Run one request and compare against the reference model.
    task automatic run_model(input bit we, input logic [1:0] sz, input bit uns,
                             input logic [31:0] addr, input logic [31:0] wd);
        int lat, we_cnt, exp_lat;
        logic [31:0] rd, wa, wdv, exp_rd;
        bit mis, busy_ready, exp_mis;
        exp_mis = model_mis(sz, addr);
        exp_rd  = (!we && !exp_mis) ? model_load(sz, uns, addr) : 32'd0;
        if (exp_mis)                        exp_lat = 1;
        else if (!we || sz == 2'd2)         exp_lat = 2;
        else                                exp_lat = 3;
        if (we && !exp_mis) model_store(sz, addr, wd);
        do_req(we, sz, uns, addr, wd, lat, rd, mis, we_cnt, wa, wdv, busy_ready);
        check("rnd_latency", 32'(lat), 32'(exp_lat));
        check("rnd_rdata", rd, exp_rd);
        check("rnd_misaligned", 32'(mis), 32'(exp_mis));
        check("rnd_we_count", 32'(we_cnt), (we && !exp_mis) ? 32'd1 : 32'd0);
        check("rnd_busy_ready", 32'(busy_ready), 32'd0);
        if (we && !exp_mis) begin
            check("rnd_mem_a", wa, {addr[31:2], 2'b00});
            check("rnd_mem_wd", wdv, model_word(addr));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, we_cnt, c, n, bad_words;
        logic [31:0] rd, wa, wdv, addr;
        logic [1:0] sz;
        bit mis, busy_ready, ready_idle, we;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'((i & ~3) >> (8 * (i & 3)));

        rst = 1'b1; preload = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        // Reset held for two cycles.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_mis", 32'(rsp_misaligned), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        rst = 1'b0; preload = 1'b0;
        @(negedge clk);

        // Word load from 0x10.
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, mis, we_cnt, wa, wdv, busy_ready);
        check("wload_latency", 32'(lat), 32'd2);
        check("wload_rdata", rd, 32'h0000_0010);
        check("wload_no_we", 32'(we_cnt), 32'd0);

        // Byte store 0xAB to 0x21, then signed and unsigned byte loads.
        model_store(2'd0, 32'h21, 32'h0000_00AB);
        do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AB, lat, rd, mis, we_cnt, wa, wdv, busy_ready);
        check("bstore_latency", 32'(lat), 32'd3);
        check("bstore_we_count", 32'(we_cnt), 32'd1);
        check("bstore_mem_a", wa, 32'h20);
        check("bstore_mem_wd", wdv, 32'h0000_AB20);
        check("bstore_rdata", rd, 32'd0);
        check("bstore_mis", 32'(mis), 32'd0);
        do_req(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, lat, rd, mis, we_cnt, wa, wdv, busy_ready);
        check("lb_signed", rd, 32'hFFFF_FFAB);
        do_req(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, lat, rd, mis, we_cnt, wa, wdv, busy_ready);
        check("lb_unsigned", rd, 32'h0000_00AB);

        // Misaligned half load at 0x13.
        do_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, lat, rd, mis, we_cnt, wa, wdv, busy_ready);
        check("mis_latency", 32'(lat), 32'd1);
        check("mis_flag", 32'(mis), 32'd1);
        check("mis_rdata", rd, 32'd0);
        check("mis_no_we", 32'(we_cnt), 32'd0);

        // Reset during the WRITE cycle of a half store to 0x42.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'h42; req_wdata = 32'h0000_BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_write", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_we_gated", 32'(mem_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_mem_kept", dmem[8'h10], 32'h0000_0040);
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_rsp_later", 32'(rsp_valid), 32'd0);

        // Back-to-back: word store then word load with req_valid held.
        model_store(2'd2, 32'h30, 32'h1234_5678);
        we_cnt = 0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h30; req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1 req_we = 1'b0; req_wdata = 32'hDEAD_BEEF;
        c = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (rsp_valid) begin c = k; break; end
        end
        check("b2b_store_latency", 32'(c), 32'd2);
        n = 0; ready_idle = 1'b0; rd = 'x;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (k == 1) ready_idle = req_ready;
            if (k == 2) req_valid = 1'b0;
            if (rsp_valid) begin n = k; rd = rsp_rdata; break; end
        end
        req_valid = 1'b0;
        check("b2b_ready_gap", 32'(ready_idle), 32'd1);
        check("b2b_load_spacing", 32'(n), 32'd3);
        check("b2b_load_rdata", rd, 32'h1234_5678);
        check("b2b_we_count", 32'(we_cnt), 32'd1);
        @(negedge clk);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 150; t++) begin
            we   = 1'($urandom);
            sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = $urandom;
            if (sz != 2'd3 && $urandom_range(0, 9) < 7)
                addr = addr & ~32'(nbytes(sz) - 1);
            run_model(we, sz, 1'($urandom), addr, $urandom);
        end

        // Whole-memory consistency with the reference.
        bad_words = 0;
        for (int i = 0; i < 256; i++)
            if (dmem[i] !== model_word(32'(i * 4))) bad_words++;
        check("mem_consistency", 32'(bad_words), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
